// File: rtl/adder_bitserial.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a registered
// carry, LSB first, with valid/ready handshakes on operands and result.

module maj3 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic m
);
    assign m = (x & y) | (x & z) | (y & z);
endmodule

module adder_bitserial_fa #(
    parameter int IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    generate
        if (IMPL_TYPE == 0) begin : g_xor_mux
            logic p;
            assign p    = a ^ b;
            assign s    = p ^ cin;
            assign cout = p ? cin : a;
        end else if (IMPL_TYPE == 1) begin : g_maj_not
            // sum = MAJ(~cout, cin, MAJ(a, b, ~cin)) is equivalent to a ^ b ^ cin.
            logic t;
            maj3 u_cout (.x(a),     .y(b),   .z(cin),  .m(cout));
            maj3 u_t    (.x(a),     .y(b),   .z(~cin), .m(t));
            maj3 u_sum  (.x(~cout), .y(cin), .z(t),    .m(s));
        end else begin : g_bad_impl
            $fatal(1, "adder_bitserial: IMPL_TYPE must be 0 or 1");
        end
    endgenerate
endmodule

module adder_bitserial #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_shift;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "adder_bitserial: WIDTH must be at least 1");
        end
    endgenerate

    adder_bitserial_fa #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Sum bits enter from the MSB side; after WIDTH shifts bit i sits at position i.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift = fa_s;
        end else begin : g_shift_wn
            assign sum_shift = {fa_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: every register here uses non-blocking assignment so all of them
    // see the same pre-edge values of carry, a_sr and b_sr within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                    // Visible results change only here, so they hold across IDLE.
                    if (cnt == LAST) begin
                        sum      <= sum_shift;
                        cout     <= fa_co;
                        overflow <= carry ^ fa_co;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_done_hold: assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !out_ready) |=>
            (state == DONE && $stable(sum) && $stable(cout) && $stable(overflow)));

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (state == RUN) |-> (cnt <= LAST));

endmodule
